qsys_mlcd_8080_wr: RTL and testbench

Avalon-MM slave that turns CPU writes into timed 8080-style write cycles on the MCU LCD bus (CS/RS/WR/RD plus 16-bit data). It sits directly downstream of the LCD data-out PIO stage and replaces software bit-banging of the strobes. Data and command words go through a small FIFO, so the Nios II core can push a burst of pixels and continue while the bus engine drains them at the programmed timing.

---
 rtl/mlcd_pkg.sv | 26 ++
 rtl/mlcd_sync_fifo.sv | 59 +++++
 rtl/qsys_mlcd_8080_wr.sv | 201 ++++++++++++++++++++
 tb/tb_qsys_mlcd_8080_wr.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlcd_pkg.sv
// Shared definitions for the 8080-style LCD write engine: FSM states,
// register addresses, STATUS bit positions and the TIMING reset value.
package mlcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_TIMING = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_IRQ_EN  = 4;
  localparam int STAT_LVL_LSB = 8;

  localparam logic [11:0] TIMING_RST = 12'h111;

endpackage

// File: rtl/mlcd_sync_fifo.sv
// Single-clock write FIFO with first-word-fall-through head, occupancy
// count (0..DEPTH) and an overflow event for pushes that are dropped.
module mlcd_sync_fifo
  import mlcd_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             wr_ok;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  // A simultaneous pop frees the slot, so a push at full is still accepted.
  assign wr_ok   = push_i && (!full_o || pop_i);
  assign ovf_o   = push_i && full_o && !pop_i;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;

  // Storage array; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap modulo depth; the separate count distinguishes full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_ok, pop_i})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/qsys_mlcd_8080_wr.sv
// Avalon-MM slave driving timed 8080-style write cycles on an MCU LCD bus.
// Optional feature: define MLCD_IRQ_EN to add the registered drain interrupt
// (irq port and STATUS[4] enable bit).
module qsys_mlcd_8080_wr
  import mlcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic              read_n,
  output logic [31:0]       readdata,
  output logic              lcd_cs_n,
  output logic              lcd_rs,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
`ifdef MLCD_IRQ_EN
  output logic              irq,
`endif
  output logic [DATA_W-1:0] lcd_data
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic              wr_en;
  logic              push;
  logic [DATA_W:0]   push_word;
  logic              pop;
  logic [DATA_W:0]   head;
  logic [LW-1:0]     level;
  logic [15:0]       level_ext;
  logic              full;
  logic              empty;
  logic              ovf_evt;
  logic              busy;
  logic              irq_en;

  logic [11:0]       timing_q;
  logic              ovf_q;
  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              cs_n_q;
  logic              rs_q;
  logic              wr_n_q;
  logic [DATA_W-1:0] data_q;

  logic              unused_ok;
  assign unused_ok = &{1'b0, writedata};

  assign wr_en     = chipselect && !write_n;
  assign push      = wr_en && ((address == ADDR_DATA) || (address == ADDR_CMD));
  assign push_word = {(address == ADDR_DATA), writedata[DATA_W-1:0]};
  assign busy      = (state_q != ST_IDLE) || !empty;
  assign level_ext = 16'(level);

  mlcd_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (pop),
    .head_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty),
    .ovf_o   (ovf_evt)
  );

  // Pop when the engine can accept a word: from IDLE, or at the end of HOLD.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state_q == ST_IDLE) pop = 1'b1;
      else if ((state_q == ST_HOLD) && (cnt_q == 4'd0)) pop = 1'b1;
    end
  end

  // Register file: TIMING, sticky overflow and (optionally) irq enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timing_q <= TIMING_RST;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en && (address == ADDR_TIMING)) timing_q <= writedata[11:0];
      if (ovf_evt) ovf_q <= 1'b1;
      else if (wr_en && (address == ADDR_STATUS) && writedata[STAT_OVF]) ovf_q <= 1'b0;
    end
  end

`ifdef MLCD_IRQ_EN
  logic irq_en_q;
  logic irq_q;
  assign irq_en = irq_en_q;
  assign irq    = irq_q;

  // Interrupt enable bit and the registered "burst fully drained" flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && (address == ADDR_STATUS)) irq_en_q <= writedata[STAT_IRQ_EN];
      irq_q <= irq_en_q && empty && (state_q == ST_IDLE);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  // Bus-cycle FSM; phase counter reloads sample TIMING, outputs are registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      cs_n_q  <= 1'b1;
      rs_q    <= 1'b1;
      wr_n_q  <= 1'b1;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            data_q  <= head[DATA_W-1:0];
            rs_q    <= head[DATA_W];
            cs_n_q  <= 1'b0;
            cnt_q   <= timing_q[3:0];
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == 4'd0) begin
            cnt_q   <= timing_q[7:4];
            wr_n_q  <= 1'b0;
            state_q <= ST_STROBE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == 4'd0) begin
            cnt_q   <= timing_q[11:8];
            wr_n_q  <= 1'b1;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == 4'd0) begin
            if (pop) begin
              data_q  <= head[DATA_W-1:0];
              rs_q    <= head[DATA_W];
              cnt_q   <= timing_q[3:0];
              state_q <= ST_SETUP;
            end else begin
              cs_n_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Zero-latency read mux; unselected or unused bits read as 0.
  always_comb begin
    readdata = 32'd0;
    if (chipselect && !read_n) begin
      case (address)
        ADDR_TIMING: readdata[11:0] = timing_q;
        ADDR_STATUS: begin
          readdata[STAT_BUSY]   = busy;
          readdata[STAT_FULL]   = full;
          readdata[STAT_EMPTY]  = empty;
          readdata[STAT_OVF]    = ovf_q;
          readdata[STAT_IRQ_EN] = irq_en;
          readdata[STAT_LVL_LSB +: 8] = level_ext[7:0];
        end
        default: readdata = 32'd0;
      endcase
    end
  end

  assign lcd_cs_n = cs_n_q;
  assign lcd_rs   = rs_q;
  assign lcd_wr_n = wr_n_q;
  assign lcd_rd_n = 1'b1;
  assign lcd_data = data_q;

endmodule

// File: tb/tb_qsys_mlcd_8080_wr.sv
// Directed bench for qsys_mlcd_8080_wr: table of single-word timing vectors
// plus hand-written burst, overflow, reset and (with MLCD_IRQ_EN) irq sequences.
module tb_qsys_mlcd_8080_wr;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic        read_n = 1'b1;
  logic [31:0] readdata;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
  logic [15:0] lcd_data;
`ifdef MLCD_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  qsys_mlcd_8080_wr #(.FIFO_DEPTH(16), .DATA_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .read_n     (read_n),
    .readdata   (readdata),
    .lcd_cs_n   (lcd_cs_n),
    .lcd_rs     (lcd_rs),
    .lcd_wr_n   (lcd_wr_n),
    .lcd_rd_n   (lcd_rd_n),
`ifdef MLCD_IRQ_EN
    .irq        (irq),
`endif
    .lcd_data   (lcd_data)
  );

  int compared = 0;
  int mismatched = 0;

  // Bus monitor, sampled on the falling edge away from the active edge.
  int          cyc = 0;
  int          push_cyc = -1;
  int          cs_fall_cyc = 0, cs_rise_cyc = 0, wr_rise_cyc = 0;
  int          bursts = 0, burst_len = 0, cs_len = 0, low_len = 0;
  int          stab_err = 0;
  int          strobe_cyc_q[$];
  int          low_q[$];
  logic        rs_seen_q[$];
  logic [15:0] dat_seen_q[$];
  logic [15:0] cur_data = 16'd0;
  logic        prev_wr_n = 1'b1, prev_cs_n = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (push_cyc < 0 && chipselect && !write_n && address <= 2'd1) push_cyc = cyc;
    if (prev_wr_n && !lcd_wr_n) begin
      strobe_cyc_q.push_back(cyc);
      rs_seen_q.push_back(lcd_rs);
      dat_seen_q.push_back(lcd_data);
      cur_data = lcd_data;
      low_len = 1;
    end else if (!lcd_wr_n) begin
      low_len++;
      if (lcd_data != cur_data) stab_err++;
    end
    if (!prev_wr_n && lcd_wr_n) begin
      low_q.push_back(low_len);
      wr_rise_cyc = cyc;
    end
    if (prev_cs_n && !lcd_cs_n) begin
      cs_fall_cyc = cyc;
      cs_len = 1;
    end else if (!lcd_cs_n) begin
      cs_len++;
    end
    if (!prev_cs_n && lcd_cs_n) begin
      cs_rise_cyc = cyc;
      bursts++;
      burst_len = cs_len;
    end
    prev_wr_n = lcd_wr_n;
    prev_cs_n = lcd_cs_n;
  end

  task automatic mon_clear();
    strobe_cyc_q.delete();
    low_q.delete();
    rs_seen_q.delete();
    dat_seen_q.delete();
    bursts = 0;
    push_cyc = -1;
    stab_err = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp_v);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    #1;
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_bursts(input int n, input int budget, input string nm);
    int k = 0;
    while (bursts < n && k < budget) begin
      step(1);
      k++;
    end
    chk(nm, 32'(bursts >= n), 32'd1);
  endtask

  typedef struct {
    logic [11:0] timing;
    logic        is_cmd;
    logic [15:0] data;
    int          exp_su;
    int          exp_wl;
    int          exp_wh;
    int          exp_cs;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int k;

    vecs[0] = '{12'h111, 1'b0, 16'h1234, 2, 2, 2, 6};
    vecs[1] = '{12'h321, 1'b0, 16'hA5C3, 2, 3, 4, 9};
    vecs[2] = '{12'h000, 1'b1, 16'h002C, 1, 1, 1, 3};
    vecs[3] = '{12'h5A3, 1'b0, 16'hFFFF, 4, 11, 6, 21};

    // Reset state
    step(3);
    chk("rst_cs_n", 32'(lcd_cs_n), 32'd1);
    chk("rst_rs",   32'(lcd_rs),   32'd1);
    chk("rst_wr_n", 32'(lcd_wr_n), 32'd1);
    chk("rst_rd_n", 32'(lcd_rd_n), 32'd1);
    chk("rst_data", 32'(lcd_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    rd(2'd2, r); chk("rst_timing", r, 32'h111);
    rd(2'd3, r); chk("rst_status", r, 32'h004);
    rd(2'd0, r); chk("data_reads_0", r, 32'h0);

    // Single-word vectors
    for (int i = 0; i < 4; i++) begin
      mon_clear();
      wr(2'd2, {20'd0, vecs[i].timing});
      rd(2'd2, r); chk($sformatf("v%0d_timing", i), r, {20'd0, vecs[i].timing});
      wr(vecs[i].is_cmd ? 2'd1 : 2'd0, {16'hDEAD, vecs[i].data});
      wait_bursts(1, 200, $sformatf("v%0d_done", i));
      chk($sformatf("v%0d_latency", i), 32'(cs_fall_cyc - push_cyc), 32'd2);
      chk($sformatf("v%0d_strobes", i), 32'(strobe_cyc_q.size()), 32'd1);
      if (strobe_cyc_q.size() >= 1 && low_q.size() >= 1) begin
        chk($sformatf("v%0d_setup", i), 32'(strobe_cyc_q[0] - cs_fall_cyc), 32'(vecs[i].exp_su));
        chk($sformatf("v%0d_strobe", i), 32'(low_q[0]), 32'(vecs[i].exp_wl));
        chk($sformatf("v%0d_hold", i), 32'(cs_rise_cyc - wr_rise_cyc), 32'(vecs[i].exp_wh));
        chk($sformatf("v%0d_rs", i), 32'(rs_seen_q[0]), 32'(!vecs[i].is_cmd));
        chk($sformatf("v%0d_data", i), 32'(dat_seen_q[0]), 32'(vecs[i].data));
      end
      chk($sformatf("v%0d_cs_len", i), 32'(burst_len), 32'(vecs[i].exp_cs));
      chk($sformatf("v%0d_stable", i), 32'(stab_err), 32'd0);
      rd(2'd3, r); chk($sformatf("v%0d_status", i), r, 32'h004);
    end

    // Back-to-back command + two pixels at reset timing
    wr(2'd2, 32'h111);
    mon_clear();
    wr(2'd1, 32'h002C);
    wr(2'd0, 32'hF800);
    wr(2'd0, 32'h07E0);
    wait_bursts(1, 100, "b2b_done");
    chk("b2b_strobes", 32'(strobe_cyc_q.size()), 32'd3);
    chk("b2b_cs_len", 32'(burst_len), 32'd18);
    if (strobe_cyc_q.size() == 3) begin
      chk("b2b_rs0", 32'(rs_seen_q[0]), 32'd0);
      chk("b2b_rs1", 32'(rs_seen_q[1]), 32'd1);
      chk("b2b_rs2", 32'(rs_seen_q[2]), 32'd1);
      chk("b2b_d1", 32'(dat_seen_q[1]), 32'hF800);
      chk("b2b_d2", 32'(dat_seen_q[2]), 32'h07E0);
      chk("b2b_per1", 32'(strobe_cyc_q[1] - strobe_cyc_q[0]), 32'd6);
      chk("b2b_per2", 32'(strobe_cyc_q[2] - strobe_cyc_q[1]), 32'd6);
    end

    // Overflow: slowest timing, FIFO_DEPTH+2 pushes on consecutive cycles
    wr(2'd2, 32'hFFF);
    mon_clear();
    for (int i = 0; i < 18; i++) wr(2'd0, 32'h100 + 32'(i));
    rd(2'd3, r); chk("ovf_status", r, 32'h100B);
    wr(2'd3, 32'h8);
    rd(2'd3, r); chk("ovf_cleared", r, 32'h1003);
    wait_bursts(1, 1200, "ovf_done");
    chk("ovf_strobes", 32'(strobe_cyc_q.size()), 32'd17);
    if (strobe_cyc_q.size() == 17) begin
      chk("ovf_first", 32'(dat_seen_q[0]), 32'h100);
      chk("ovf_last", 32'(dat_seen_q[16]), 32'h110);
      chk("ovf_period", 32'(strobe_cyc_q[1] - strobe_cyc_q[0]), 32'd48);
    end
    rd(2'd3, r); chk("ovf_final", r, 32'h004);

    // Asynchronous reset while the strobe is low
    wr(2'd2, 32'h321);
    wr(2'd0, 32'hBEEF);
    wr(2'd0, 32'hCAFE);
    wr(2'd0, 32'h1111);
    k = 0;
    while (lcd_wr_n && k < 20) begin
      step(1);
      k++;
    end
    chk("rstmid_strobe_seen", 32'(lcd_wr_n), 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rstmid_wr_n", 32'(lcd_wr_n), 32'd1);
    chk("rstmid_cs_n", 32'(lcd_cs_n), 32'd1);
    chk("rstmid_data", 32'(lcd_data), 32'd0);
    chk("rstmid_rs",   32'(lcd_rs),   32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    mon_clear();
    rd(2'd3, r); chk("rstmid_status", r, 32'h004);
    rd(2'd2, r); chk("rstmid_timing", r, 32'h111);
    step(20);
    chk("rstmid_no_strobe", 32'(strobe_cyc_q.size()), 32'd0);

`ifdef MLCD_IRQ_EN
    // Drain interrupt
    wr(2'd3, 32'h10);
    rd(2'd3, r); chk("irq_en_rd", r, 32'h014);
    step(2);
    chk("irq_idle", 32'(irq), 32'd1);
    mon_clear();
    wr(2'd0, 32'h0001);
    wr(2'd0, 32'h0002);
    step(2);
    chk("irq_burst", 32'(irq), 32'd0);
    wait_bursts(1, 100, "irq_done");
    step(2);
    chk("irq_drained", 32'(irq), 32'd1);
    wr(2'd0, 32'h0003);
    step(2);
    chk("irq_cleared", 32'(irq), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
